// File: rtl/cache_op_unit_if.sv
// rtl/cache_op_unit_if.sv - CACHE-op request, tag-array and writeback signal bundle
interface cache_op_unit_if #(
   parameter int INDEX_W  = 7,
   parameter int OFFSET_W = 5,
   parameter int WAYS     = 2
);
   localparam int TAG_W = 32 - OFFSET_W - INDEX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [4:0]                  cache_op;
   logic [31:0]                 cache_paddr;
   logic [1:0]                  cache_target;
   logic                        cache_op_done;
   logic                        cache_busy;
   logic [31:0]                 cp0_taglo;

   logic                        tag_rd_en;
   logic [1:0]                  tag_rd_sel;
   logic [INDEX_W-1:0]          tag_rd_index;
   logic [WAYS*(TAG_W+2)-1:0]   tag_rd_data;

   logic                        tag_wr_en;
   logic [1:0]                  tag_wr_sel;
   logic [INDEX_W-1:0]          tag_wr_index;
   logic [WAY_W-1:0]            tag_wr_way;
   logic [TAG_W+1:0]            tag_wr_data;

   logic                        wb_req;
   logic [INDEX_W-1:0]          wb_index;
   logic [WAY_W-1:0]            wb_way;
   logic [TAG_W-1:0]            wb_tag;
   logic                        wb_ack;

   modport slave (
      input  cache_op, cache_paddr, cache_target, cp0_taglo, tag_rd_data, wb_ack,
      output cache_op_done, cache_busy,
      output tag_rd_en, tag_rd_sel, tag_rd_index,
      output tag_wr_en, tag_wr_sel, tag_wr_index, tag_wr_way, tag_wr_data,
      output wb_req, wb_index, wb_way, wb_tag
   );

   modport master (
      output cache_op, cache_paddr, cache_target, cp0_taglo, tag_rd_data, wb_ack,
      input  cache_op_done, cache_busy,
      input  tag_rd_en, tag_rd_sel, tag_rd_index,
      input  tag_wr_en, tag_wr_sel, tag_wr_index, tag_wr_way, tag_wr_data,
      input  wb_req, wb_index, wb_way, wb_tag
   );
endinterface

// File: rtl/cache_op_unit.sv
// rtl/cache_op_unit.sv - MIPS CACHE-instruction responder for the writeback stage
module cache_op_unit #(
   parameter int INDEX_W  = 7,
   parameter int OFFSET_W = 5,
   parameter int WAYS     = 2
) (
   input logic            clk,
   input logic            resetn,
   cache_op_unit_if.slave bus
);
   localparam int TAG_W = 32 - OFFSET_W - INDEX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int ENT_W = TAG_W + 2;

   localparam logic [2:0] OP_IDX_INV   = 3'b000;
   localparam logic [2:0] OP_STORE_TAG = 3'b010;
   localparam logic [2:0] OP_HIT_INV   = 3'b100;
   localparam logic [2:0] OP_HIT_WBINV = 3'b101;
   localparam logic [1:0] TGT_D        = 2'b10;
   localparam logic [1:0] TGT_BAD      = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_CHECK, S_WB, S_WRITE, S_DONE, S_HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [31:0]        paddr_q, paddr_d;
   logic [1:0]         target_q, target_d;
   logic               tag_rd_en_q, tag_rd_en_d;
   logic               tag_wr_en_q, tag_wr_en_d;
   logic [WAY_W-1:0]   tag_wr_way_q, tag_wr_way_d;
   logic [ENT_W-1:0]   tag_wr_data_q, tag_wr_data_d;
   logic               wb_req_q, wb_req_d;
   logic [WAY_W-1:0]   wb_way_q, wb_way_d;
   logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
   logic               done_q, done_d;

   logic [ENT_W-1:0]   entry [WAYS];
   logic               hit;
   logic [WAY_W-1:0]   hit_way, addr_way, sel_way;
   logic [ENT_W-1:0]   sel_entry;
   logic               change, need_wb;
   logic [ENT_W-1:0]   store_entry;
   logic               unused_bits;

   // Lowest-numbered matching way wins, so scan down and let the last match stick.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         entry[w] = bus.tag_rd_data[w*ENT_W +: ENT_W];
         if (entry[w][ENT_W-1] && (entry[w][TAG_W-1:0] == paddr_q[31 -: TAG_W])) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   assign addr_way    = paddr_q[OFFSET_W+INDEX_W +: WAY_W];
   assign sel_way     = (op_q == OP_IDX_INV) ? addr_way : hit_way;
   assign sel_entry   = entry[sel_way];
   assign change      = (op_q == OP_IDX_INV) || hit;
   assign need_wb     = change && (op_q != OP_HIT_INV) && (target_q == TGT_D) &&
                        sel_entry[ENT_W-1] && sel_entry[ENT_W-2];
   assign store_entry = {bus.cp0_taglo[7], bus.cp0_taglo[6], TAG_W'(bus.cp0_taglo[31:12])};

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      paddr_d       = paddr_q;
      target_d      = target_q;
      tag_rd_en_d   = 1'b0;
      tag_wr_en_d   = 1'b0;
      tag_wr_way_d  = tag_wr_way_q;
      tag_wr_data_d = tag_wr_data_q;
      wb_req_d      = wb_req_q;
      wb_way_d      = wb_way_q;
      wb_tag_d      = wb_tag_q;
      done_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cache_target != 2'b00) begin
               op_d     = bus.cache_op[4:2];
               paddr_d  = bus.cache_paddr;
               target_d = bus.cache_target;
               if (bus.cache_target == TGT_BAD) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  case (bus.cache_op[4:2])
                     OP_STORE_TAG: begin
                        state_d       = S_WRITE;
                        tag_wr_en_d   = 1'b1;
                        tag_wr_way_d  = bus.cache_paddr[OFFSET_W+INDEX_W +: WAY_W];
                        tag_wr_data_d = store_entry;
                     end
                     OP_IDX_INV, OP_HIT_INV: begin
                        state_d     = S_READ;
                        tag_rd_en_d = 1'b1;
                     end
                     OP_HIT_WBINV: begin
                        if (bus.cache_target == TGT_D) begin
                           state_d     = S_READ;
                           tag_rd_en_d = 1'b1;
                        end else begin
                           state_d = S_DONE;
                           done_d  = 1'b1;
                        end
                     end
                     default: begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                     end
                  endcase
               end
            end
         end
         S_READ: state_d = S_CHECK;
         S_CHECK: begin
            tag_wr_way_d  = sel_way;
            tag_wr_data_d = '0;
            if (need_wb) begin
               state_d  = S_WB;
               wb_req_d = 1'b1;
               wb_way_d = sel_way;
               wb_tag_d = sel_entry[TAG_W-1:0];
            end else if (change) begin
               state_d     = S_WRITE;
               tag_wr_en_d = 1'b1;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_WB: begin
            if (bus.wb_ack) begin
               state_d     = S_WRITE;
               wb_req_d    = 1'b0;
               tag_wr_en_d = 1'b1;
            end
         end
         S_WRITE: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         S_DONE: state_d = S_HOLD;
         // Held target from the same instruction must not retrigger.
         S_HOLD: if (bus.cache_target == 2'b00) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         paddr_q       <= '0;
         target_q      <= '0;
         tag_rd_en_q   <= 1'b0;
         tag_wr_en_q   <= 1'b0;
         tag_wr_way_q  <= '0;
         tag_wr_data_q <= '0;
         wb_req_q      <= 1'b0;
         wb_way_q      <= '0;
         wb_tag_q      <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         paddr_q       <= paddr_d;
         target_q      <= target_d;
         tag_rd_en_q   <= tag_rd_en_d;
         tag_wr_en_q   <= tag_wr_en_d;
         tag_wr_way_q  <= tag_wr_way_d;
         tag_wr_data_q <= tag_wr_data_d;
         wb_req_q      <= wb_req_d;
         wb_way_q      <= wb_way_d;
         wb_tag_q      <= wb_tag_d;
         done_q        <= done_d;
      end
   end

   assign bus.cache_op_done = done_q;
   assign bus.cache_busy    = (state_q != S_IDLE) && (state_q != S_HOLD);
   assign bus.tag_rd_en     = tag_rd_en_q;
   assign bus.tag_rd_sel    = target_q;
   assign bus.tag_rd_index  = paddr_q[OFFSET_W +: INDEX_W];
   assign bus.tag_wr_en     = tag_wr_en_q;
   assign bus.tag_wr_sel    = target_q;
   assign bus.tag_wr_index  = paddr_q[OFFSET_W +: INDEX_W];
   assign bus.tag_wr_way    = tag_wr_way_q;
   assign bus.tag_wr_data   = tag_wr_data_q;
   assign bus.wb_req        = wb_req_q;
   assign bus.wb_index      = paddr_q[OFFSET_W +: INDEX_W];
   assign bus.wb_way        = wb_way_q;
   assign bus.wb_tag        = wb_tag_q;

   assign unused_bits = ^{bus.cache_op[1:0], paddr_q[OFFSET_W-1:0],
                          bus.cp0_taglo[11:8], bus.cp0_taglo[5:0]};
endmodule

// File: doc/cache_op_unit.md
# cache_op_unit

Responder side of the writeback-stage CACHE-instruction handshake. Accepts the latched cache opcode, physical address and target (I/D) from the writeback stage. Executes the MIPS CACHE operation against the selected cache's tag array, including a dirty-line writeback through the dcache refill/writeback engine. Returns a one-cycle `cache_op_done` pulse. Sits between the writeback stage and the icache/dcache tag arrays.

## Interface
- `INDEX_W`, 7: set-index bits; `TAG_W = 32 - OFFSET_W - INDEX_W`.
- `OFFSET_W`, 5: line-offset bits (32-byte lines).
- `WAYS`, 2: associativity, power of 2; `WAY_W = log2(WAYS)`, minimum 1.
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `cache_op` in 5: CACHE op field; [4:2] = operation, [1:0] = cache.
- `cache_paddr` in 32: physical address.
- `cache_target` in 2: 01 = icache, 10 = dcache, 00 = no request, 11 = invalid.
- `cache_op_done` out 1: one-cycle completion pulse.
- `cache_busy` out 1: an operation is in progress.
- `cp0_taglo` in 32: TagLo for Index Store Tag.
  - tag = [31:12] truncated to TAG_W.
  - valid = [7].
  - dirty = [6].
- `tag_rd_en` out 1, `tag_rd_sel` out 2, `tag_rd_index` out INDEX_W: tag-array read request.
- `tag_rd_data` in WAYS*(TAG_W+2): read data, valid the cycle after `tag_rd_en`. Way w sits at `[w*(TAG_W+2) +: TAG_W+2]` as {valid, dirty, tag}.
- `tag_wr_en` out 1, `tag_wr_sel` out 2, `tag_wr_index` out INDEX_W, `tag_wr_way` out WAY_W, `tag_wr_data` out TAG_W+2: tag-array write.
- `wb_req` out 1, `wb_index` out INDEX_W, `wb_way` out WAY_W, `wb_tag` out TAG_W: dcache line writeback request.
- `wb_ack` in 1: one-cycle pulse when the writeback is complete.

## Operation

**Address fields**
- index = `paddr[OFFSET_W +: INDEX_W]`.
- way (index ops only) = `paddr[OFFSET_W+INDEX_W +: WAY_W]`.
- tag = `paddr[31 -: TAG_W]`.

**Operations**
- 000 Index Invalidate:
  - icache: invalidate the entry.
  - dcache: index writeback-invalidate.
- 010 Index Store Tag: write the TagLo-derived entry; no read.
- 100 Hit Invalidate: invalidate the hit way, no writeback; on a miss, do nothing.
- 101 Hit Writeback Invalidate:
  - dcache only.
  - Writes back if the line is valid and dirty, then invalidates.
  - On icache it is a NOP.
- Any other op code, or target 11: NOP, which completes immediately.

**Writeback rule:** writeback happens only when the selected entry is valid, dirty, and the target is dcache.

**Invalidation:** writes {valid 0, dirty 0, tag 0}.

**Multiple hits:** the lowest-numbered way wins.

**States**
- **IDLE**
  - If `cache_target != 0`: latch op, paddr, target, taglo.
  - Store Tag → WRITE.
  - NOP → DONE.
  - Otherwise → READ.
- **READ:** `tag_rd_en = 1` with the latched sel/index → CHECK.
- **CHECK:** evaluate `tag_rd_data`.
  - Writeback needed → WB.
  - Entry must change → WRITE.
  - Otherwise (hit-miss) → DONE.
- **WB:** `wb_req` held high with stable `wb_index`/`wb_way`/`wb_tag` until `wb_ack` → WRITE.
- **WRITE:** `tag_wr_en = 1` for one cycle → DONE.
- **DONE:** `cache_op_done = 1` → HOLD.
- **HOLD:** wait for `cache_target == 00` → IDLE. This prevents retriggering on a still-held target.

**Registered state:** all control outputs are decoded from registered state and latched operands. Inputs are sampled only in IDLE.

**`cache_busy`** = state ∉ {IDLE, HOLD}.

## Timing
- Reset values while `resetn = 0`, taking effect on the clock edge:
  - state IDLE.
  - All outputs and latched operands 0.
  - `cache_busy = 0`.
- Reset mid-operation (including during WB) abandons the operation. The writeback engine is reset by the same signal.
- Latency from acceptance edge t0, with `cache_op_done` high in cycle:
  - NOP: t1.
  - Store Tag: t2 (WRITE t1).
  - Hit miss: t3 (READ t1, CHECK t2).
  - Invalidate without writeback: t4 (WRITE t3).
  - Writeback path: WRITE is the cycle after `wb_ack` is sampled; done follows one cycle later.
- `cache_target` dropping mid-operation (writeback-stage flush) does not abort. The operation completes and `cache_op_done` still pulses once.
- A new request is accepted only from IDLE.
- `wb_ack` arriving outside WB is ignored.

## Test plan
All scenarios use default parameters.

1. Op 00000, target 01, paddr 0x0000_1234 → expected:
   - `tag_rd_index` 0x11 at t1.
   - `tag_wr_en` at t3 with way 1, index 0x11, data 0.
   - done at t4.
   - `wb_req` never asserts.
2. Op 10101, target 10, paddr 0x0000_1234, way0 = {1,1,0x00001} → expected:
   - `wb_req` from t3 with index 0x11, way 0, tag 0x00001, held stable.
   - `wb_ack` 5 cycles later → `tag_wr_en` the next cycle with way 0, data 0.
   - done one cycle after that.
3. Op 10001, target 10, no way matching tag 0x00001 → no `tag_wr_en`, no `wb_req`, done at t3.
4. Op 01001, target 10, taglo 0xABCD_E0C0, paddr 0x0000_0020 → expected:
   - `tag_wr_en` at t1 with index 0x01, way 0, data {1,1,0xABCDE}.
   - done at t2.
5. Handshake sequence:
   - Target held at 10 for 3 cycles after done → no second operation starts.
   - Target drops to 00, then a new request → accepted.
   - Target 11 → done at t1, no array access.
6. `resetn` low in WB state → next cycle `wb_req = 0`, `cache_busy = 0`, `cache_op_done = 0`. A later `wb_ack` pulse causes no activity.
